// File: rtl/sa_autosa_autosahls_shiftleftsu_pipe.sv
// Two-stage pipelined signed left shifter with saturation on a valid/ready stream.
// Optional saturation event counter on sat_cnt when AUTOSA_SHL_SAT_CNT_EN is defined.
module sa_autosa_autosahls_shiftleftsu_pipe #(
  parameter int unsigned IN_WIDTH    = 32,
  parameter int unsigned OUT_WIDTH   = 49,
  parameter int unsigned SHIFT_WIDTH = 6
) (
  input  logic                   autosa_core_clk,
  input  logic                   autosa_core_rst,
  input  logic                   in_pvld,
  output logic                   in_prdy,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic [SHIFT_WIDTH-1:0] in_shift,
  output logic                   out_pvld,
  input  logic                   out_prdy,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_sat
`ifdef AUTOSA_SHL_SAT_CNT_EN
  ,
  output logic [31:0]            sat_cnt
`endif
);

  // Wide enough that no shift amount can push a set bit off the top.
  localparam int unsigned EXT_W = OUT_WIDTH + (1 << SHIFT_WIDTH);
  localparam int unsigned TOP_W = EXT_W - OUT_WIDTH + 1;
  localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic                   s1_vld_q,   s1_vld_d;
  logic [IN_WIDTH-1:0]    s1_data_q,  s1_data_d;
  logic [SHIFT_WIDTH-1:0] s1_shift_q, s1_shift_d;
  logic                   s2_vld_q,   s2_vld_d;
  logic [OUT_WIDTH-1:0]   s2_data_q,  s2_data_d;
  logic                   s2_sat_q,   s2_sat_d;

  logic                   s1_adv_c;
  logic                   s2_adv_c;
  logic                   sign_c;
  logic [EXT_W-1:0]       ext_c;
  logic [EXT_W-1:0]       shl_c;
  logic                   sat_c;
  logic [OUT_WIDTH-1:0]   res_c;

  // A stage may load when empty or when its contents leave this cycle.
  always_comb begin
    s2_adv_c = !s2_vld_q || out_prdy;
    s1_adv_c = !s1_vld_q || s2_adv_c;
  end

  assign in_prdy = s1_adv_c;

  // Saturate when any bit discarded at or above the output sign position disagrees with the sign.
  always_comb begin
    sign_c = s1_data_q[IN_WIDTH-1];
    ext_c  = {{(EXT_W-IN_WIDTH){sign_c}}, s1_data_q};
    shl_c  = ext_c << s1_shift_q;
    sat_c  = (shl_c[EXT_W-1:OUT_WIDTH-1] != {TOP_W{sign_c}});
    res_c  = sat_c ? (sign_c ? SAT_MIN : SAT_MAX) : shl_c[OUT_WIDTH-1:0];
  end

  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_data_d  = s1_data_q;
    s1_shift_d = s1_shift_q;
    s2_vld_d   = s2_vld_q;
    s2_data_d  = s2_data_q;
    s2_sat_d   = s2_sat_q;
    if (s1_adv_c) begin
      s1_vld_d = in_pvld;
      if (in_pvld) begin
        s1_data_d  = in_data;
        s1_shift_d = in_shift;
      end
    end
    if (s2_adv_c) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_data_d = res_c;
        s2_sat_d  = sat_c;
      end
    end
  end

  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      s1_shift_q <= '0;
      s2_vld_q   <= 1'b0;
      s2_data_q  <= '0;
      s2_sat_q   <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_data_q  <= s1_data_d;
      s1_shift_q <= s1_shift_d;
      s2_vld_q   <= s2_vld_d;
      s2_data_q  <= s2_data_d;
      s2_sat_q   <= s2_sat_d;
    end
  end

  assign out_pvld = s2_vld_q;
  assign out_data = s2_data_q;
  assign out_sat  = s2_sat_q;

`ifdef AUTOSA_SHL_SAT_CNT_EN
  logic [31:0] sat_cnt_q, sat_cnt_d;

  // Count saturated beats as they are handed off; sticks at all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (s2_vld_q && out_prdy && s2_sat_q && !(&sat_cnt_q)) begin
      sat_cnt_d = sat_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_sa_autosa_autosahls_shiftleftsu_pipe.sv
// Self-checking bench for the pipelined saturating left shifter: directed, backpressure, random and reset scenarios.
module tb_sa_autosa_autosahls_shiftleftsu_pipe;
  localparam int unsigned IW = 32;
  localparam int unsigned OW = 49;
  localparam int unsigned SW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_pvld;
  logic          in_prdy;
  logic [IW-1:0] in_data;
  logic [SW-1:0] in_shift;
  logic          out_pvld;
  logic          out_prdy;
  logic [OW-1:0] out_data;
  logic          out_sat;
`ifdef AUTOSA_SHL_SAT_CNT_EN
  logic [31:0]   sat_cnt;
`endif

  always #5 clk = ~clk;

  sa_autosa_autosahls_shiftleftsu_pipe #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW)
  ) dut (
    .autosa_core_clk(clk),
    .autosa_core_rst(rst),
    .in_pvld(in_pvld),
    .in_prdy(in_prdy),
    .in_data(in_data),
    .in_shift(in_shift),
    .out_pvld(out_pvld),
    .out_prdy(out_prdy),
    .out_data(out_data),
    .out_sat(out_sat)
`ifdef AUTOSA_SHL_SAT_CNT_EN
    ,
    .sat_cnt(sat_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int unsigned sat_exp = 0;

  logic [IW-1:0] sq_d[$];
  logic [SW-1:0] sq_s[$];
  bit            sq_has[$];
  logic [OW-1:0] sq_ed[$];
  logic          sq_es[$];
  logic [OW-1:0] eq_d[$];
  logic          eq_s[$];
  int            eq_t[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Infinite-precision product compared against the signed output range.
  task automatic ref_model(input logic [IW-1:0] d, input logic [SW-1:0] sh,
                           output logic [OW-1:0] o, output logic s);
    logic signed [127:0] r, p, mx, mn;
    r  = {{(128-IW){d[IW-1]}}, d};
    p  = 128'sd1 <<< sh;
    r  = r * p;
    mx = (128'sd1 <<< (OW-1)) - 128'sd1;
    mn = -(128'sd1 <<< (OW-1));
    if (r > mx) begin
      o = mx[OW-1:0]; s = 1'b1;
    end else if (r < mn) begin
      o = mn[OW-1:0]; s = 1'b1;
    end else begin
      o = r[OW-1:0]; s = 1'b0;
    end
  endtask

  task automatic push_model(input logic [IW-1:0] d, input logic [SW-1:0] sh);
    sq_d.push_back(d); sq_s.push_back(sh); sq_has.push_back(1'b0);
    sq_ed.push_back('0); sq_es.push_back(1'b0);
  endtask

  task automatic push_exp(input logic [IW-1:0] d, input logic [SW-1:0] sh,
                          input logic [OW-1:0] ed, input logic es);
    sq_d.push_back(d); sq_s.push_back(sh); sq_has.push_back(1'b1);
    sq_ed.push_back(ed); sq_es.push_back(es);
  endtask

  // Drive queued stimulus and score every output beat until everything has drained.
  task automatic run(input bit rnd_prdy, input bit rnd_gap, input int budget);
    logic [OW-1:0] hold_d = '0;
    logic          hold_s = 1'b0;
    bit            stalled = 1'b0;
    int            n = 0;
    logic [OW-1:0] md;
    logic          ms;
    while ((sq_d.size() > 0 || eq_d.size() > 0) && n < budget) begin
      @(negedge clk);
      cyc++; n++;
      out_prdy = rnd_prdy ? 1'($urandom_range(0, 1)) : 1'b1;
      in_pvld  = (sq_d.size() > 0) && !(rnd_gap && $urandom_range(0, 3) == 0);
      in_data  = in_pvld ? sq_d[0] : IW'($urandom);
      in_shift = in_pvld ? sq_s[0] : SW'($urandom);
      #1;
      if (stalled) begin
        chk("hold_vld", 64'(out_pvld), 64'(1'b1));
        chk("hold_data", 64'(out_data), 64'(hold_d));
        chk("hold_sat", 64'(out_sat), 64'(hold_s));
      end
      chk("in_prdy", 64'(in_prdy), 64'(!(eq_d.size() == 2 && !out_prdy)));
      if (out_pvld && out_prdy) begin
        if (eq_d.size() == 0) begin
          chk("spurious_beat", 64'(out_data), 64'hDEAD_BEEF_DEAD_BEEF);
        end else begin
          chk("out_data", 64'(out_data), 64'(eq_d[0]));
          chk("out_sat", 64'(out_sat), 64'(eq_s[0]));
          if (!rnd_prdy) chk("latency", 64'(cyc - eq_t[0]), 64'd2);
          if (eq_s[0]) sat_exp++;
          void'(eq_d.pop_front()); void'(eq_s.pop_front()); void'(eq_t.pop_front());
        end
      end
      stalled = out_pvld && !out_prdy;
      hold_d  = out_data;
      hold_s  = out_sat;
      if (in_pvld && in_prdy) begin
        if (sq_has[0]) begin
          md = sq_ed[0]; ms = sq_es[0];
        end else begin
          ref_model(sq_d[0], sq_s[0], md, ms);
        end
        eq_d.push_back(md); eq_s.push_back(ms); eq_t.push_back(cyc);
        void'(sq_d.pop_front()); void'(sq_s.pop_front()); void'(sq_has.pop_front());
        void'(sq_ed.pop_front()); void'(sq_es.pop_front());
      end
    end
    chk("drain", 64'(sq_d.size() + eq_d.size()), 64'd0);
    @(negedge clk);
    cyc++;
    in_pvld = 1'b0;
    #1;
    chk("idle_vld", 64'(out_pvld), 64'd0);
`ifdef AUTOSA_SHL_SAT_CNT_EN
    chk("sat_cnt", 64'(sat_cnt), 64'(sat_exp));
`endif
  endtask

  initial begin
    logic [IW-1:0] d;
    rst = 1'b1; in_pvld = 1'b0; in_data = '0; in_shift = '0; out_prdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_pvld", 64'(out_pvld), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    chk("rst_in_prdy", 64'(in_prdy), 64'd1);
`ifdef AUTOSA_SHL_SAT_CNT_EN
    chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
`endif

    // Single saturating beat first so the counter reads exactly 1 afterwards.
    push_exp(32'd1, 6'd48, 49'h0FFFFFFFFFFFF, 1'b1);
    run(1'b0, 1'b0, 20);

    push_exp(32'd1,          6'd47, 49'h0800000000000, 1'b0);
    push_exp(32'hFFFFFFFF,   6'd48, 49'h1000000000000, 1'b0);
    push_exp(32'hFFFFFFFE,   6'd48, 49'h1000000000000, 1'b1);
    push_exp(32'h7FFFFFFF,   6'd17, 49'h0FFFFFFFE0000, 1'b0);
    push_exp(32'h7FFFFFFF,   6'd18, 49'h0FFFFFFFFFFFF, 1'b1);
    push_exp(32'd0,          6'd63, 49'h0000000000000, 1'b0);
    push_exp(32'd5,          6'd63, 49'h0FFFFFFFFFFFF, 1'b1);
    push_exp(32'hFFFFFFFB,   6'd63, 49'h1000000000000, 1'b1);
    push_exp(32'hFFFFFFFF,   6'd0,  49'h1FFFFFFFFFFFF, 1'b0);
    run(1'b0, 1'b0, 50);

    for (int i = 1; i <= 8; i++) push_exp(IW'(i), 6'd0, OW'(i), 1'b0);
    run(1'b1, 1'b0, 200);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0: d = 32'd0;
        1: d = 32'hFFFFFFFF;
        2: d = 32'h7FFFFFFF;
        3: d = 32'h80000000;
        4: d = IW'($urandom_range(0, 15));
        default: d = IW'($urandom);
      endcase
      push_model(d, SW'($urandom_range(0, 63)));
    end
    run(1'b1, 1'b1, 5000);

    // Fill both stages under backpressure, then reset.
    @(negedge clk);
    out_prdy = 1'b0; in_pvld = 1'b1; in_data = 32'd3; in_shift = 6'd0;
    @(negedge clk);
    in_data = 32'd4;
    @(negedge clk);
    in_pvld = 1'b0;
    #1;
    chk("full_in_prdy", 64'(in_prdy), 64'd0);
    chk("full_out_pvld", 64'(out_pvld), 64'd1);
    chk("full_out_data", 64'(out_data), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_out_pvld", 64'(out_pvld), 64'd0);
    chk("mid_rst_in_prdy", 64'(in_prdy), 64'd1);
    rst = 1'b0;
    sat_exp = 0;
    push_exp(32'd9, 6'd1, 49'd18, 1'b0);
    run(1'b0, 1'b0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
